// File: rtl/stage_tag_pkg.sv
// stage_tag shared types: reduction op encodings and key bit layout.
// Imported by the interface, the tag reducer and the stage top.
package stage_tag_pkg;

  localparam int KEY_W       = 5;
  localparam int TAG_INV_BIT = 2;

  typedef enum logic [1:0] {
    OP_XNOR = 2'b00,
    OP_OR   = 2'b01,
    OP_AND  = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

endpackage

// File: rtl/stage_tag_if.sv
// Valid/ready bundle around stage_tag: upstream beat in, tagged word out.
// master = the side that drives beats and out_ready; slave = the stage.
interface stage_tag_if
  import stage_tag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 1
) ();

  logic [KEY_W-1:0]        key_bits;
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W+TAG_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output key_bits, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  key_bits, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/stage_tag_tag_reduce.sv
// Per-slice reduction of a data word into TAG_W tag bits.
// Purely combinational; key[2] inverts every tag bit.
module tag_reduce
  import stage_tag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 1
) (
  input  logic [DATA_W-1:0]    data,
  input  logic [TAG_INV_BIT:0] key,
  output logic [TAG_W-1:0]     tag
);

  localparam int S = DATA_W / TAG_W;

  op_e op;
  assign op = op_e'(key[1:0]);

  for (genvar i = 0; i < TAG_W; i++) begin : g_sl
    logic [S-1:0] sl;
    logic         r;

    assign sl = data[i*S +: S];

    always_comb begin
      r = 1'b0;
      unique case (op)
        OP_XNOR: r = ~^sl;
        OP_OR:   r = |sl;
        OP_AND:  r = &sl;
        OP_XOR:  r = ^sl;
      endcase
    end

    assign tag[i] = r ^ key[TAG_INV_BIT];
  end

endmodule

// File: rtl/stage_tag.sv
// Tagging pipeline stage: appends slice-reduction tags to each beat and
// buffers tagged words in a small FIFO with a saturating pop counter.
module stage_tag
  import stage_tag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 1,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk2,
  input  logic             rst_n,
  stage_tag_if.slave       io,
  output logic [CNT_W-1:0] blk_count,
  output logic             busy
);

  localparam int OW = DATA_W + TAG_W;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  logic [OW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      occ;
  logic [TAG_W-1:0] tag;
  logic             push;
  logic             pop;
  logic             unused_key;

  tag_reduce #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_tag (
    .data (io.in_data),
    .key  (io.key_bits[TAG_INV_BIT:0]),
    .tag  (tag)
  );

  assign unused_key = ^io.key_bits[KEY_W-1:TAG_INV_BIT+1];

  // Full blocks a push even when a pop happens the same cycle.
  assign io.in_ready  = rst_n && (occ != OCC_FULL);
  assign io.out_valid = (occ != '0);
  assign io.out_data  = mem[rptr];
  assign busy         = io.out_valid;

  assign push = io.in_valid && io.in_ready;
  assign pop  = io.out_valid && io.out_ready && rst_n;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      blk_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (pop && (blk_count != '1))
        blk_count <= blk_count + 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk2) begin
    if (push) mem[wptr] <= {io.in_data, tag};
  end

endmodule

// File: tb/tb_stage_tag.sv
// Bench for stage_tag: two configurations share one stimulus stream and
// are checked every cycle against an index-based FIFO model.
module tb_stage_tag;

  logic        clk2 = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [4:0]  key = '0;
  logic        out_ready = 1'b0;

  always #5 clk2 = ~clk2;

  stage_tag_if #(.DATA_W(16), .TAG_W(1)) ifa ();
  stage_tag_if #(.DATA_W(16), .TAG_W(4)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.key_bits  = key;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.key_bits  = key;
  assign ifb.out_ready = out_ready;

  logic [15:0] blk_a;
  logic [3:0]  blk_b;
  logic        busy_a;
  logic        busy_b;

  stage_tag #(.DATA_W(16), .TAG_W(1), .DEPTH(2), .CNT_W(16)) dut_a (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .io        (ifa),
    .blk_count (blk_a),
    .busy      (busy_a)
  );

  stage_tag #(.DATA_W(16), .TAG_W(4), .DEPTH(4), .CNT_W(4)) dut_b (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .io        (ifb),
    .blk_count (blk_b),
    .busy      (busy_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Tagged word from the rules: count ones per slice, decide the bit.
  function automatic logic [19:0] tword(input logic [15:0] d,
                                        input logic [4:0] k,
                                        input int tw);
    int s;
    int ones;
    bit r;
    logic [19:0] w;
    s = 16 / tw;
    w = 20'(d) << tw;
    for (int i = 0; i < tw; i++) begin
      ones = 0;
      for (int b = 0; b < s; b++) ones += int'(d[i*s+b]);
      case (k[1:0])
        2'd0:    r = (ones % 2 == 0);
        2'd1:    r = (ones > 0);
        2'd2:    r = (ones == s);
        default: r = (ones % 2 == 1);
      endcase
      if (k[2]) r = !r;
      w[i] = r;
    end
    return w;
  endfunction

  logic [19:0] loga [4096];
  logic [19:0] logb [4096];
  int wa = 0, ra = 0, ca = 0;
  int wb = 0, rb = 0, cb = 0;

  always @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      wa <= 0; ra <= 0; ca <= 0;
      wb <= 0; rb <= 0; cb <= 0;
    end else begin
      if (in_valid && wa - ra < 2) begin
        loga[wa % 4096] <= tword(in_data, key, 1);
        wa <= wa + 1;
      end
      if (out_ready && wa != ra) begin
        ra <= ra + 1;
        ca <= (ca == 65535) ? ca : ca + 1;
      end
      if (in_valid && wb - rb < 4) begin
        logb[wb % 4096] <= tword(in_data, key, 4);
        wb <= wb + 1;
      end
      if (out_ready && wb != rb) begin
        rb <= rb + 1;
        cb <= (cb == 15) ? cb : cb + 1;
      end
    end
  end

  always @(negedge clk2) begin
    chk("a_in_ready", ifa.in_ready, rst_n && (wa - ra < 2));
    chk("a_out_valid", ifa.out_valid, wa != ra);
    chk("a_busy", busy_a, wa != ra);
    chk("a_blk", blk_a, ca);
    if (wa != ra) chk("a_out_data", ifa.out_data, loga[ra % 4096][16:0]);
    chk("b_in_ready", ifb.in_ready, rst_n && (wb - rb < 4));
    chk("b_out_valid", ifb.out_valid, wb != rb);
    chk("b_busy", busy_b, wb != rb);
    chk("b_blk", blk_b, cb);
    if (wb != rb) chk("b_out_data", ifb.out_data, logb[rb % 4096]);
  end

  logic [16:0] popa [$];

  always @(posedge clk2) begin
    if (rst_n && ifa.out_valid && out_ready) popa.push_back(ifa.out_data);
  end

  task automatic send(input logic [15:0] d, input logic [4:0] k,
                      input logic [16:0] ea, input logic [19:0] eb,
                      input bit useb);
    in_valid = 1'b1;
    in_data  = d;
    key      = k;
    @(negedge clk2);
    chk("lat_valid", ifa.out_valid, 1);
    chk("tag_a", ifa.out_data, ea);
    if (useb) chk("tag_b", ifb.out_data, eb);
    #1 in_valid = 1'b0;
    @(negedge clk2);
    #1;
  endtask

  initial begin
    @(negedge clk2);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk2);
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_blk", blk_a, 0);
    #1;

    send(16'h0003, 5'b00000, 17'h00007, 20'h0, 1'b0);
    send(16'h0000, 5'b00001, 17'h00000, 20'h0, 1'b0);
    send(16'hFFFF, 5'b00010, 17'h1FFFF, 20'h0, 1'b0);
    send(16'h0001, 5'b00011, 17'h00003, 20'h0, 1'b0);
    send(16'h0001, 5'b00111, 17'h00002, 20'h0, 1'b0);
    send(16'hF0F1, 5'b00011, 17'h1E1E3, 20'hF0F11, 1'b1);
    send(16'hF0F1, 5'b00000, 17'h1E1E2, 20'hF0F1E, 1'b1);
    send(16'h0003, 5'b11000, 17'h00007, 20'h0, 1'b0);

    // backpressure: A, B fill depth 2, C waits until a pop frees a slot
    popa.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    key       = 5'b00011;
    @(negedge clk2);
    #1 in_data = 16'h00FF;
    key = 5'b00001;
    @(negedge clk2);
    chk("bp_full_after_b", ifa.in_ready, 0);
    #1 in_data = 16'h8000;
    key = 5'b00010;
    repeat (3) begin
      @(negedge clk2);
      chk("bp_hold_valid", ifa.out_valid, 1);
      chk("bp_hold_data", ifa.out_data, 17'h02469);
      chk("bp_hold_full", ifa.in_ready, 0);
    end
    #1 out_ready = 1'b1;
    @(negedge clk2);
    chk("bp_ready_rise", ifa.in_ready, 1);
    chk("bp_head_b", ifa.out_data, 17'h001FF);
    @(negedge clk2);
    chk("bp_head_c", ifa.out_data, 17'h10000);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk2);
    chk("bp_pop_count", popa.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (popa.size() > i) begin
        case (i)
          0:       chk("bp_order", popa[i], 17'h02469);
          1:       chk("bp_order", popa[i], 17'h001FF);
          default: chk("bp_order", popa[i], 17'h10000);
        endcase
      end
    end
    chk("bp_blk", blk_a, 11);
    #1;

    // throughput: one word per cycle with continuous traffic
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'($urandom);
      key     = 5'($urandom);
      @(negedge clk2);
      chk("tp_valid", ifa.out_valid, 1);
      chk("tp_ready", ifa.in_ready, 1);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk2);
    chk("tp_blk", blk_a, 19);
    chk("tp_empty", ifa.out_valid, 0);
    #1;

    // reset with two words buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hABCD;
    repeat (2) begin
      @(negedge clk2);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ifa.out_valid, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_blk_a", blk_a, 0);
    chk("mid_rst_blk_b", blk_b, 0);
    @(negedge clk2);
    #1 rst_n = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk2);
    chk("post_rst_empty", ifa.out_valid, 0);
    #1;
    send(16'h0001, 5'b00011, 17'h00003, 20'h00011, 1'b1);
    chk("post_rst_blk", blk_a, 1);

    in_valid = 1'b1;
    repeat (20) begin
      in_data = 16'($urandom);
      key     = 5'($urandom);
      @(negedge clk2);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk2);
    chk("sat_blk_a", blk_a, 21);
    chk("sat_blk_b", blk_b, 15);
    #1;

    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      key       = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk2);
      #1;
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk2);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
